// File: rtl/cpu_pkg.sv
// Shared processor types: widths, opcodes and the fetch state encoding.
// Illegal-opcode halting is built only with IFU_ILLEGAL_HALT_EN defined.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 10;

  localparam logic [3:0] OP_ADD         = 4'b0000;
  localparam logic [3:0] OP_SUB         = 4'b0001;
  localparam logic [3:0] OP_AND         = 4'b0010;
  localparam logic [3:0] OP_OR          = 4'b0011;
  localparam logic [3:0] OP_XOR         = 4'b0100;
  localparam logic [3:0] OP_NOT         = 4'b0101;
  localparam logic [3:0] OP_SHL         = 4'b0110;
  localparam logic [3:0] OP_SHR         = 4'b0111;
  localparam logic [3:0] OP_LDI         = 4'b1000;
  localparam logic [3:0] OP_JMP         = 4'b1001;
  localparam logic [3:0] OP_JZ          = 4'b1010;
  localparam logic [3:0] OP_LOAD        = 4'b1011;
  localparam logic [3:0] OP_STORE       = 4'b1100;
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1101;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIRECT,
    HALT
  } fetch_state_e;

  function automatic logic is_illegal(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: 4] >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry holding register with load, drain and clear.
// Clear wins over load, load wins over drain.
module ifu_skid_buf #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         vld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, synchronous ROM reads, skid-buffered presentation.
// IFU_ILLEGAL_HALT_EN adds a sticky HALT on opcodes 1101..1111.
module instr_fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               load_PC,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  localparam int SW = INSTR_W + ADDR_W;

  fetch_state_e state, state_nxt;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  pend_addr;
  logic               pending;
  logic               issue;
  logic               jump;
  logic               take;
  logic               illegal;
  logic               skid_vld;
  logic [SW-1:0]      skid_q;
  logic [INSTR_W-1:0] pres_data;
  logic [ADDR_W-1:0]  pres_addr;

  assign jump = load_PC && (state != HALT);
  assign take = !stall && (skid_vld || pending);

  assign pres_data = skid_vld ? skid_q[ADDR_W +: INSTR_W] : imem_data;
  assign pres_addr = skid_vld ? skid_q[ADDR_W-1:0] : pend_addr;

`ifdef IFU_ILLEGAL_HALT_EN
  assign illegal = take && is_illegal(pres_data);
  assign halted  = (state == HALT);
`else
  assign illegal = 1'b0;
  assign halted  = 1'b0;
`endif

  ifu_skid_buf #(.W(SW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (stall && pending),
    .drain (take && skid_vld),
    .clear (jump),
    .d     ({imem_data, pend_addr}),
    .q     (skid_q),
    .vld   (skid_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT, REDIRECT: state_nxt = RUN;
      RUN:            state_nxt = RUN;
      HALT:           state_nxt = HALT;
      default:        state_nxt = BOOT;
    endcase
    if (jump)         state_nxt = REDIRECT;
    else if (illegal) state_nxt = HALT;
  end

  // Reset gates the issue so the ROM sees no read while rst is high
  always_comb begin
    issue = 1'b0;
    if (!rst) begin
      unique case (state)
        BOOT, REDIRECT: issue = 1'b1;
        RUN:            issue = !stall;
        HALT:           issue = 1'b0;
        default:        issue = 1'b0;
      endcase
    end
  end

  assign imem_en   = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= '0;
      pend_addr   <= '0;
      pending     <= 1'b0;
      instruction <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
    end else if (state != HALT) begin
      if (jump) begin
        fetch_pc    <= pc_value;
        pending     <= 1'b0;
        instr_valid <= 1'b0;
      end else begin
        pending <= issue;
        if (issue) begin
          fetch_pc  <= fetch_pc + 1'b1;
          pend_addr <= fetch_pc;
        end
        if (take) begin
          instruction <= pres_data;
          pc          <= pres_addr;
          instr_valid <= !illegal;
        end else if (!stall) begin
          instr_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural synchronous ROM.
// Expected words come from the ROM table fill rule below.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_en;
  logic [7:0] imem_addr;
  logic [9:0] imem_data;
  logic       stall;
  logic       load_PC;
  logic [7:0] pc_value;
  logic [9:0] instruction;
  logic       instr_valid;
  logic [7:0] pc;
  logic       halted;

  int errs = 0;
  int chks = 0;

  logic [9:0] rom [256];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .load_PC     (load_PC),
    .pc_value    (pc_value),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  always @(posedge clk) if (imem_en) imem_data <= rom[imem_addr];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] a,
                             input logic [9:0] w);
    check({tag, ".valid"}, instr_valid, 1);
    check({tag, ".pc"}, pc, a);
    check({tag, ".instr"}, instruction, w);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = i[7:0];
      rom[i] = {2'b00, a};
    end
    rom[0]    = 10'h005;
    rom[1]    = 10'h0C8;
    rom[2]    = 10'h113;
    rom[3]    = 10'h1FF;
    rom[8'h80] = 10'h340;
    imem_data = '0;

    rst = 1'b1; stall = 1'b0; load_PC = 1'b0; pc_value = '0;
    #12;
    check("rst.instr", instruction, 0);
    check("rst.valid", instr_valid, 0);
    check("rst.pc", pc, 0);
    check("rst.halted", halted, 0);
    check("rst.imem_en", imem_en, 0);

    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("boot.imem_en", imem_en, 1);
    check("boot.addr", imem_addr, 0);
    tick(2);
    expect_word("s0", 8'd0, 10'h005);
    tick(1); expect_word("s1", 8'd1, 10'h0C8);
    tick(1); expect_word("s2", 8'd2, 10'h113);
    tick(1); expect_word("s3", 8'd3, 10'h1FF);
    tick(2); expect_word("s5", 8'd5, 10'h005);

    stall = 1'b1;
    #1;
    check("stall.imem_en", imem_en, 0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      expect_word("stall.hold", 8'd5, 10'h005);
      check("stall.en", imem_en, 0);
    end
    stall = 1'b0;
    tick(1); expect_word("unst6", 8'd6, 10'h006);
    tick(1); expect_word("unst7", 8'd7, 10'h007);
    tick(3); expect_word("s10", 8'd10, 10'h00A);

    load_PC = 1'b1; pc_value = 8'h40;
    tick(1);
    load_PC = 1'b0;
    check("jmp.v0", instr_valid, 0);
    tick(1);
    check("jmp.v1", instr_valid, 0);
    check("jmp.no11", pc, 8'd10);
    tick(1); expect_word("jmp40", 8'h40, 10'h040);
    tick(1); expect_word("jmp41", 8'h41, 10'h041);

    load_PC = 1'b1; pc_value = 8'hFE;
    tick(1);
    load_PC = 1'b0;
    tick(2); expect_word("wFE", 8'hFE, 10'h0FE);
    tick(1); expect_word("wFF", 8'hFF, 10'h0FF);
    tick(1); expect_word("w00", 8'h00, 10'h005);
    tick(1); expect_word("w01", 8'h01, 10'h0C8);

    rst = 1'b1;
    #1;
    check("arst.instr", instruction, 0);
    check("arst.valid", instr_valid, 0);
    check("arst.pc", pc, 0);
    check("arst.en", imem_en, 0);
    tick(1);
    rst = 1'b0;
    tick(2); expect_word("rb0", 8'd0, 10'h005);

    load_PC = 1'b1; stall = 1'b1; pc_value = 8'h20;
    tick(1);
    load_PC = 1'b0;
    check("js.v", instr_valid, 0);
    check("js.en", imem_en, 1);
    check("js.addr", imem_addr, 8'h20);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("js.hold.v", instr_valid, 0);
      check("js.hold.en", imem_en, 0);
    end
    stall = 1'b0;
    tick(1); expect_word("js20", 8'h20, 10'h020);
    tick(1); expect_word("js21", 8'h21, 10'h021);

    load_PC = 1'b1; pc_value = 8'h7F;
    tick(1);
    load_PC = 1'b0;
    tick(2); expect_word("h7F", 8'h7F, 10'h07F);
    tick(1);
    check("ill.instr", instruction, 10'h340);
`ifdef IFU_ILLEGAL_HALT_EN
    check("ill.valid", instr_valid, 0);
    check("ill.halted", halted, 1);
    load_PC = 1'b1; pc_value = 8'h00;
    tick(2);
    load_PC = 1'b0;
    check("halt.keep", halted, 1);
    check("halt.en", imem_en, 0);
    check("halt.instr", instruction, 10'h340);
    check("halt.valid", instr_valid, 0);
`else
    check("ill.valid", instr_valid, 1);
    check("ill.pc", pc, 8'h80);
    check("ill.halted", halted, 0);
    tick(1); expect_word("ill81", 8'h81, 10'h081);
`endif

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
